uart_rx_module: RTL and testbench

- 8N1 UART receiver: the far-end counterpart of the design's UART transmit path.
- Oversamples the asynchronous serial line with a bit-period counter and recovers one byte per frame.
- Presents each byte on a one-entry valid/ready output buffer.
- Used on the host/loopback side to capture sensor bytes sent by the design's UART transmitter; bit timing matches that transmitter.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_module_if.sv | 21 ++
 rtl/uart_rx_module_sync_2ff.sv | 24 ++
 rtl/uart_rx_module.sv | 130 +++++++++++++
 tb/tb_uart_rx_module.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and timing defaults.
// Used by both the receive and transmit paths.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEF = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_e;

endpackage

// File: rtl/uart_rx_module_if.sv
// One-entry byte output buffer handshake of the UART receiver.
// master drives data/valid, slave returns ready.
interface uart_rx_module_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_module_sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// Reset value selects the idle level seen before the first sample.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff <= {2{RST_VAL}};
    end else begin
      ff <= {ff[0], d};
    end
  end

  assign q = ff[1];

endmodule

// File: rtl/uart_rx_module.sv
// 8N1 UART receiver with a one-entry valid/ready byte buffer.
// Samples mid-bit and returns to IDLE at mid stop bit.
module uart_rx_module
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  uart_rx_module_if.master  rxo,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);

  logic          rx_s;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          stop_ok, stop_bad;
  logic [7:0]    data_q;
  logic          valid_q, fe_q, ov_q;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    sh_d     = sh_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL) begin
          cnt_d       = '0;
          sh_d[idx_q] = rx_s;
          if (idx_q == LAST) state_d = STOP;
          else               idx_d   = idx_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL) begin
          cnt_d    = '0;
          stop_ok  = rx_s;
          stop_bad = !rx_s;
          state_d  = rx_s ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  // A full buffer being drained this cycle still accepts the new byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      fe_q <= stop_bad;
      ov_q <= 1'b0;
      if (stop_ok) begin
        if (!valid_q || rxo.rx_ready) begin
          data_q  <= sh_q;
          valid_q <= 1'b1;
        end else begin
          ov_q <= 1'b1;
        end
      end else if (valid_q && rxo.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rxo.rx_data  = data_q;
  assign rxo.rx_valid = valid_q;
  assign frame_err    = fe_q;
  assign overrun      = ov_q;

endmodule

// File: tb/tb_uart_rx_module.sv
// Randomized self-checking bench for uart_rx_module.
// Expected bytes and flags come from what the bench transmits.
module tb_uart_rx_module;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;
  logic busy, frame_err, overrun;

  uart_rx_module_if bus();

  uart_rx_module #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rxo       (bus),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_cnt = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (busy) busy_cnt++;
      if (bus.rx_valid && bus.rx_ready)
        got_q.push_back(bus.rx_data);
      if (bus.rx_valid && !prev_valid)
        rise_cyc = cyc;
      prev_valid = bus.rx_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(logic [7:0] b, logic stop_val,
                            int stop_bits);
    rx = 1'b0;
    start_cyc = cyc;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_val;
    tick(CPB * stop_bits);
    rx = 1'b1;
  endtask

  task automatic wait_valid(int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (bus.rx_valid) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic pulse_ready();
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic ok;
    int fe0, ov0, bs0, base, drop, lat, k;
    logic [7:0] b, first;
    logic [7:0] sent[$];

    bus.rx_ready = 1'b0;
    tick(3);
    check("rst_valid", 32'(bus.rx_valid), 0);
    check("rst_data", 32'(bus.rx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fe", 32'(frame_err), 0);
    check("rst_ov", 32'(overrun), 0);
    rst = 1'b1;
    tick(5);

    // single byte held without ready, then drained
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1, 1);
    wait_valid(20, ok);
    check("a5_valid", 32'(ok), 1);
    check("a5_data", 32'(bus.rx_data), 32'hA5);
    lat = rise_cyc - start_cyc;
    check("a5_latency", 32'(lat >= 154 && lat <= 156), 1);
    drop = 0;
    repeat (100) begin
      tick();
      if (!bus.rx_valid || bus.rx_data !== 8'hA5) drop++;
    end
    check("a5_hold", 32'(drop), 0);
    pulse_ready();
    check("a5_cleared", 32'(bus.rx_valid), 0);
    check("a5_data_kept", 32'(bus.rx_data), 32'hA5);
    check("a5_fe", 32'(fe_cnt - fe0), 0);
    check("a5_ov", 32'(ov_cnt - ov0), 0);

    // short start glitch
    bs0 = busy_cnt;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    check("glitch_busy_seen", 32'(busy_cnt != bs0), 1);
    check("glitch_idle", 32'(busy), 0);
    check("glitch_valid", 32'(bus.rx_valid), 0);
    check("glitch_fe", 32'(fe_cnt - fe0), 0);
    check("glitch_ov", 32'(ov_cnt - ov0), 0);

    // break-length stop bit
    send_frame(8'h3C, 1'b0, 3);
    check("brk_busy", 32'(busy), 1);
    rx = 1'b1;
    tick(5);
    check("brk_idle", 32'(busy), 0);
    check("brk_fe", 32'(fe_cnt - fe0), 1);
    check("brk_valid", 32'(bus.rx_valid), 0);
    send_frame(8'h5A, 1'b1, 1);
    wait_valid(20, ok);
    check("5a_valid", 32'(ok), 1);
    check("5a_data", 32'(bus.rx_data), 32'h5A);
    pulse_ready();
    tick(2);

    // overrun, then streaming with ready held
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1);
    send_frame(8'h22, 1'b1, 1);
    tick(4);
    check("ovr_data", 32'(bus.rx_data), 32'h11);
    check("ovr_valid", 32'(bus.rx_valid), 1);
    check("ovr_pulse", 32'(ov_cnt - ov0), 1);
    base = got_q.size();
    bus.rx_ready = 1'b1;
    send_frame(8'h33, 1'b1, 1);
    send_frame(8'h44, 1'b1, 1);
    tick(4);
    check("stream_ov", 32'(ov_cnt - ov0), 1);
    check("stream_data", 32'(bus.rx_data), 32'h44);
    check("stream_n", 32'(got_q.size() - base), 3);
    if (got_q.size() - base == 3) begin
      check("stream_0", 32'(got_q[base]), 32'h11);
      check("stream_1", 32'(got_q[base+1]), 32'h33);
      check("stream_2", 32'(got_q[base+2]), 32'h44);
    end
    bus.rx_ready = 1'b0;
    tick(2);

    // reset in the middle of 0xFF
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(4 * CPB);
    rst = 1'b0;
    #1;
    check("mrst_valid", 32'(bus.rx_valid), 0);
    check("mrst_data", 32'(bus.rx_data), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_flags", 32'({frame_err, overrun}), 0);
    tick(2);
    rst = 1'b1;
    tick(5 * CPB - 3);
    base = got_q.size();
    fe0 = fe_cnt;
    bus.rx_ready = 1'b1;
    send_frame(8'h81, 1'b1, 1);
    tick(4);
    check("mrst_n", 32'(got_q.size() - base), 1);
    if (got_q.size() > base)
      check("mrst_byte", 32'(got_q[base]), 32'h81);
    check("mrst_fe", 32'(fe_cnt - fe0), 0);

    // back-to-back frames, ready held
    base = got_q.size();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h00, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1);
    send_frame(8'h55, 1'b1, 1);
    tick(4);
    check("b2b_n", 32'(got_q.size() - base), 3);
    if (got_q.size() - base == 3) begin
      check("b2b_0", 32'(got_q[base]), 32'h00);
      check("b2b_1", 32'(got_q[base+1]), 32'hFF);
      check("b2b_2", 32'(got_q[base+2]), 32'h55);
    end

    // random bytes, gaps and stop lengths
    base = got_q.size();
    sent.delete();
    repeat (10) begin
      b = 8'($urandom);
      sent.push_back(b);
      send_frame(b, 1'b1, $urandom_range(1, 2));
      tick($urandom_range(0, 20));
    end
    tick(4);
    check("rnd_n", 32'(got_q.size() - base), 10);
    for (int i = 0; i < 10; i++)
      if (base + i < got_q.size())
        check("rnd_byte", 32'(got_q[base+i]), 32'(sent[i]));
    check("rnd_fe", 32'(fe_cnt - fe0), 0);
    check("rnd_ov", 32'(ov_cnt - ov0), 0);
    bus.rx_ready = 1'b0;

    // random bursts into a stalled buffer
    repeat (3) begin
      k = $urandom_range(1, 3);
      ov0 = ov_cnt;
      first = 8'($urandom);
      for (int i = 0; i < k; i++) begin
        b = (i == 0) ? first : 8'($urandom);
        send_frame(b, 1'b1, 1);
        tick($urandom_range(0, 8));
      end
      tick(4);
      check("burst_valid", 32'(bus.rx_valid), 1);
      check("burst_data", 32'(bus.rx_data), 32'(first));
      check("burst_ov", 32'(ov_cnt - ov0), 32'(k - 1));
      base = got_q.size();
      pulse_ready();
      tick();
      check("burst_drain", 32'(bus.rx_valid), 0);
      check("burst_take_n", 32'(got_q.size() - base), 1);
      if (got_q.size() > base)
        check("burst_take", 32'(got_q[base]), 32'(first));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
